// File: rtl/div_if.sv
// Request/response bundle between the execute stage and the iterative divider.
// Master drives operands, cancel and out_ready; slave returns in_ready and the held result.
interface div_if;
    logic        cancel;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x;
    logic [31:0] y;
    logic        div_signed;
    logic        use_mod;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] div_result;
    logic        div_by_zero;

    modport master (
        output cancel, in_valid, x, y, div_signed, use_mod, out_ready,
        input  in_ready, out_valid, div_result, div_by_zero
    );

    modport slave (
        input  cancel, in_valid, x, y, div_signed, use_mod, out_ready,
        output in_ready, out_valid, div_result, div_by_zero
    );
endinterface

// File: rtl/div.sv
// 32-bit restoring divider (quotient or remainder, signed or unsigned); optional DIV_FAST_EN early-out.
// Latency: out_valid rises 34 cycles after accept (2 on the fast path when DIV_FAST_EN is defined).
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE and masked by cancel.
module div (
    input  logic clk,
    input  logic resetn,
    div_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

    state_t      state, state_nxt;
    logic [63:0] acc;
    logic [31:0] dvs;
    logic [5:0]  cnt;
    logic        q_neg, r_neg, mod_sel, zero_flag;

    logic        x_neg, y_neg, y_zero, accept, fast, keep, handshake;
    logic [31:0] x_mag, y_mag, quo_fix, rem_fix;
    logic [32:0] trial;
    logic [63:0] acc_iter;

    assign x_neg     = bus.div_signed & bus.x[31];
    assign y_neg     = bus.div_signed & bus.y[31];
    assign x_mag     = x_neg ? (32'd0 - bus.x) : bus.x;
    assign y_mag     = y_neg ? (32'd0 - bus.y) : bus.y;
    assign y_zero    = (bus.y == 32'd0);
    assign bus.in_ready = (state == IDLE) & ~bus.cancel;
    assign accept    = bus.in_valid & bus.in_ready;
    assign handshake = bus.out_valid & bus.out_ready;

`ifdef DIV_FAST_EN
    assign fast = y_zero | (x_mag < y_mag);
`else
    assign fast = 1'b0;
`endif

    // acc[63:31] is the upper 33 bits after the left shift; the partial remainder
    // is always below dvs, so a 33-bit difference is enough to carry the sign.
    assign trial    = acc[63:31] - {1'b0, dvs};
    assign keep     = ~trial[32];
    assign acc_iter = keep ? {trial[31:0], acc[30:0], 1'b1} : {acc[62:0], 1'b0};

    // Divide-by-zero leaves an all-ones quotient untouched; the remainder still
    // gets its sign back so it reproduces x exactly.
    assign quo_fix = (q_neg & ~zero_flag) ? (32'd0 - acc[31:0]) : acc[31:0];
    assign rem_fix = r_neg ? (32'd0 - acc[63:32]) : acc[63:32];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = fast ? FIX : BUSY;
            BUSY: if (cnt == 6'd31) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: if (handshake) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (bus.cancel) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // out_valid is registered one cycle after the result lands in DONE.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) bus.out_valid <= 1'b0;
        else         bus.out_valid <= (state == DONE) & ~bus.cancel & ~handshake;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc             <= 64'd0;
            dvs             <= 32'd0;
            cnt             <= 6'd0;
            q_neg           <= 1'b0;
            r_neg           <= 1'b0;
            mod_sel         <= 1'b0;
            zero_flag       <= 1'b0;
            bus.div_result  <= 32'd0;
            bus.div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    acc       <= fast ? {x_mag, {32{y_zero}}} : {32'd0, x_mag};
                    dvs       <= y_mag;
                    cnt       <= 6'd0;
                    q_neg     <= x_neg ^ y_neg;
                    r_neg     <= x_neg;
                    mod_sel   <= bus.use_mod;
                    zero_flag <= y_zero;
                end
                BUSY: begin
                    acc <= acc_iter;
                    cnt <= cnt + 6'd1;
                end
                FIX: if (!bus.cancel) begin
                    bus.div_result  <= mod_sel ? rem_fix : quo_fix;
                    bus.div_by_zero <= zero_flag;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_div.sv
// Scoreboard bench for div: directed vectors plus a reference-model sweep, handshake, cancel and reset cases.
module tb_div;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    bit   strict = 1'b1;
    bit   seen_valid = 1'b0;

    typedef struct {
        logic [31:0] res;
        logic        dbz;
        int          lat;
        int          acc;
    } exp_t;
    exp_t exp_q[$];

    div_if bus();

    div dut (.clk(clk), .resetn(resetn), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [31:0] mag(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (32'd0 - v) : v;
    endfunction

    // Reference result via 64-bit arithmetic, avoiding the 32-bit overflow trap.
    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic sgn, input logic md);
        longint sa, sb, q, r;
        if (b == 32'd0) return md ? a : 32'hFFFF_FFFF;
        sa = sgn ? longint'($signed(a)) : longint'({32'd0, a});
        sb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
        q = sa / sb;
        r = sa % sb;
        return md ? r[31:0] : q[31:0];
    endfunction

    function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b, input logic sgn);
`ifdef DIV_FAST_EN
        if (b == 32'd0 || mag(a, sgn) < mag(b, sgn)) return 2;
`endif
        return 34 + 0 * int'(a[0] ^ b[0] ^ sgn);
    endfunction

    // Monitor: samples at negedge, where inputs (driven at posedge+1) are stable for the next edge.
    always @(negedge clk) begin
        if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
                if (strict) chk("unexpected_out_valid", 64'(bus.out_valid), 64'd0);
            end else begin
                if (!seen_valid) begin
                    chk("latency", 64'(cyc - exp_q[0].acc), 64'(exp_q[0].lat));
                    seen_valid = 1'b1;
                end
                if (bus.out_ready) begin
                    chk("div_result", 64'(bus.div_result), 64'(exp_q[0].res));
                    chk("div_by_zero", 64'(bus.div_by_zero), 64'(exp_q[0].dbz));
                    void'(exp_q.pop_front());
                    seen_valid = 1'b0;
                end
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input logic md, input bit push);
        exp_t e;
        int   waited;
        @(posedge clk); #1;
        bus.x = a; bus.y = b; bus.div_signed = sgn; bus.use_mod = md; bus.in_valid = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!bus.in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) begin
            chk("in_ready_timeout", 64'(bus.in_ready), 64'd1);
        end else if (push) begin
            e.res = ref_div(a, b, sgn, md);
            e.dbz = (b == 32'd0);
            e.lat = exp_lat(a, b, sgn);
            e.acc = cyc + 1;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic issue_hc(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                            input logic md, input logic [31:0] res, input logic dbz);
        exp_t e;
        int   waited;
        @(posedge clk); #1;
        bus.x = a; bus.y = b; bus.div_signed = sgn; bus.use_mod = md; bus.in_valid = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!bus.in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) begin
            chk("in_ready_timeout", 64'(bus.in_ready), 64'd1);
        end else begin
            e.res = res;
            e.dbz = dbz;
            e.lat = exp_lat(a, b, sgn);
            e.acc = cyc + 1;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
            seen_valid = 1'b0;
        end
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.out_valid) chk("out_valid_timeout", 64'(bus.out_valid), 64'd1);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rs, rm;
        bus.cancel = 1'b0; bus.in_valid = 1'b0; bus.x = '0; bus.y = '0;
        bus.div_signed = 1'b0; bus.use_mod = 1'b0; bus.out_ready = 1'b1;
        #23 resetn = 1'b1;
        @(negedge clk);
        chk("reset_state", {60'd0, bus.in_ready, bus.out_valid, bus.div_by_zero, 1'b0},
            {60'd0, 1'b1, 1'b0, 1'b0, 1'b0});
        chk("reset_result", 64'(bus.div_result), 64'd0);

        // Hand-computed directed vectors: {x, y, signed, mod, result, div_by_zero}
        issue_hc(32'd100,       32'd7,         1'b0, 1'b0, 32'd14,        1'b0); drain();
        issue_hc(32'd100,       32'd7,         1'b0, 1'b1, 32'd2,         1'b0); drain();
        issue_hc(32'hFFFF_FFF9, 32'd2,         1'b1, 1'b0, 32'hFFFF_FFFD, 1'b0); drain();
        issue_hc(32'hFFFF_FFF9, 32'd2,         1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0); drain();
        issue_hc(32'd7,         32'hFFFF_FFFE, 1'b1, 1'b0, 32'hFFFF_FFFD, 1'b0); drain();
        issue_hc(32'd7,         32'hFFFF_FFFE, 1'b1, 1'b1, 32'd1,         1'b0); drain();
        issue_hc(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 1'b0, 32'd14,        1'b0); drain();
        issue_hc(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0); drain();
        issue_hc(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h8000_0000, 1'b0); drain();
        issue_hc(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'd0,         1'b0); drain();
        issue_hc(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0,         1'b0); drain();
        issue_hc(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h8000_0000, 1'b0); drain();
        issue_hc(32'h1234_5678, 32'd0,         1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1); drain();
        issue_hc(32'h1234_5678, 32'd0,         1'b1, 1'b1, 32'h1234_5678, 1'b1); drain();
        issue_hc(32'h1234_5678, 32'd0,         1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1); drain();
        issue_hc(32'h1234_5678, 32'd0,         1'b0, 1'b1, 32'h1234_5678, 1'b1); drain();
        issue_hc(32'hFFFF_FFF9, 32'd0,         1'b1, 1'b1, 32'hFFFF_FFF9, 1'b1); drain();

        // Held result under backpressure, then release.
        bus.out_ready = 1'b0;
        issue_hc(32'd100, 32'd7, 1'b0, 1'b0, 32'd14, 1'b0);
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            chk("hold_stable", {29'd0, bus.out_valid, bus.in_ready, bus.div_by_zero, bus.div_result},
                {29'd0, 1'b1, 1'b0, 1'b0, 32'd14});
            @(negedge clk);
        end
        @(posedge clk); #1 bus.out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle_after_handshake", {62'd0, bus.in_ready, bus.out_valid}, {62'd0, 1'b1, 1'b0});
        drain();

        // Cancel at iteration 15, then a clean request.
        issue(32'd1000, 32'd3, 1'b0, 1'b0, 1'b0);
        repeat (14) @(posedge clk);
        #1 bus.cancel = 1'b1;
        @(posedge clk); #1 bus.cancel = 1'b0;
        @(negedge clk);
        chk("cancel_to_idle", {62'd0, bus.in_ready, bus.out_valid}, {62'd0, 1'b1, 1'b0});
        repeat (40) @(negedge clk);
        issue_hc(32'd1000, 32'd3, 1'b0, 1'b0, 32'd333, 1'b0); drain();

        // Cancel together with in_valid in IDLE must not accept.
        @(posedge clk); #1;
        bus.cancel = 1'b1; bus.in_valid = 1'b1; bus.x = 32'd9; bus.y = 32'd3;
        @(negedge clk);
        chk("cancel_masks_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk); #1;
        bus.cancel = 1'b0; bus.in_valid = 1'b0;
        @(negedge clk);
        chk("cancel_no_accept", 64'(bus.in_ready), 64'd1);
        repeat (40) @(negedge clk);

        // Asynchronous reset mid-BUSY and mid-DONE.
        strict = 1'b0;
        issue(32'd5000, 32'd7, 1'b0, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        @(negedge clk); #1 resetn = 1'b0;
        #1 chk("areset_busy", {62'd0, bus.in_ready, bus.out_valid}, {62'd0, 1'b1, 1'b0});
        @(posedge clk); #1 resetn = 1'b1;
        bus.out_ready = 1'b0;
        issue(32'd5000, 32'd7, 1'b0, 1'b0, 1'b0);
        wait_valid();
        #1 resetn = 1'b0;
        #1 chk("areset_done", {62'd0, bus.in_ready, bus.out_valid}, {62'd0, 1'b1, 1'b0});
        @(posedge clk); #1 resetn = 1'b1; bus.out_ready = 1'b1;
        @(negedge clk);
        strict = 1'b1;

        // Reference-model sweep.
        for (int i = 0; i < 250; i++) begin
            ra = $urandom;
            rb = (i % 5 == 0) ? (32'($urandom) >> $urandom_range(31, 0)) : 32'($urandom);
            if (i % 40 == 0) rb = 32'd0;
            rs = 1'($urandom_range(1, 0));
            rm = 1'($urandom_range(1, 0));
            issue(ra, rb, rs, rm, 1'b1);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
